// File: rtl/decoder_seq_gen.sv
// Select-code generator for decoder3_8: a 3-bit up/down code that advances on a
// programmable prescaler in RUN, or by single step in PAUSE. tick/wrap mark each advance.
module decoder_seq_gen #(
  parameter int unsigned       CNT_W   = 24,
  parameter logic [CNT_W-1:0]  CNT_MAX = 24'd9_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic start,
  input  logic stop,
  input  logic step,
  input  logic dir,
  output logic out1,
  output logic out2,
  output logic out3,
  output logic tick,
  output logic wrap,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       code, code_nxt, code_adv;
  logic             adv, wrap_adv;

  // Advance arithmetic; dir is only consumed when an advance actually happens.
  always_comb begin
    code_adv = dir ? code + 3'd1 : code - 3'd1;
    wrap_adv = dir ? (code == 3'd7) : (code == 3'd0);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // stop outranks start, which outranks step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !stop) state_nxt = RUN;
      RUN:     if (stop) state_nxt = PAUSE;
      PAUSE: begin
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt  = cnt;
    code_nxt = code;
    adv      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        code_nxt = '0;
      end
      RUN: begin
        if (!stop) begin
          if (cnt == CNT_MAX) begin
            cnt_nxt = '0;
            adv     = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      PAUSE: begin
        // cnt is kept on resume so RUN continues from where it was frozen.
        if (stop) begin
          cnt_nxt  = '0;
          code_nxt = '0;
        end else if (!start && step) begin
          adv = 1'b1;
        end
      end
      default: begin
        cnt_nxt  = '0;
        code_nxt = '0;
      end
    endcase
    if (adv) code_nxt = code_adv;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt  <= '0;
      code <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      code <= code_nxt;
      tick <= adv;
      wrap <= adv && wrap_adv;
      busy <= (state_nxt == RUN);
    end
  end

  assign {out1, out2, out3} = code;

endmodule

// File: tb/tb_decoder_seq_gen.sv
// Scoreboard bench for decoder_seq_gen with a 5-clock advance period.
// Expected advances (cycle, code, wrap) are queued when stimulus is driven and popped on each tick.
module tb_decoder_seq_gen;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, step = 1'b0, dir = 1'b1;
  logic out1, out2, out3, tick, wrap, busy;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [2:0] code;
    logic       wrap;
  } exp_t;
  exp_t sb[$];

  decoder_seq_gen #(.CNT_MAX(24'd4)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (start),
    .stop    (stop),
    .step    (step),
    .dir     (dir),
    .out1    (out1),
    .out2    (out2),
    .out3    (out3),
    .tick    (tick),
    .wrap    (wrap),
    .busy    (busy)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [2:0] code, input logic w);
    exp_t e;
    e.cyc  = c;
    e.code = code;
    e.wrap = w;
    sb.push_back(e);
  endtask

  // Called at a falling edge: the pulse is sampled by the next rising edge (cyc+1).
  task automatic pulse(input logic a, input logic b, input logic c);
    start = a;
    stop  = b;
    step  = c;
    @(negedge sys_clk);
    start = 1'b0;
    stop  = 1'b0;
    step  = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  // Monitor: every tick must match the head of the scoreboard; no advance may go missing.
  always @(negedge sys_clk) begin
    if (mon_en && !sys_rst) begin
      if (tick === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_tick", tick, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("tick_cyc", cyc, e.cyc);
          check("tick_code", {out1, out2, out3}, e.code);
          check("tick_wrap", wrap, e.wrap);
        end
      end else begin
        check("idle_wrap", wrap, 1'b0);
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
          check("missing_tick", tick, 1'b1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int e;

    // 1: asynchronous reset between edges
    #12 sys_rst = 1'b1;
    #1;
    check("rst_code", {out1, out2, out3}, 3'd0);
    check("rst_tick", tick, 1'b0);
    check("rst_wrap", wrap, 1'b0);
    check("rst_busy", busy, 1'b0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    mon_en  = 1'b1;

    // 2: count up through a full lap
    dir = 1'b1;
    e = cyc + 1;
    for (int k = 1; k <= 8; k++) push(e + 5 * k, 3'(k), k == 8);
    pulse(1'b1, 1'b0, 1'b0);
    check("t2_busy", busy, 1'b1);
    drain("t2_drain");
    pulse(1'b0, 1'b1, 1'b0);
    check("t2_pause_busy", busy, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("t2_idle_code", {out1, out2, out3}, 3'd0);

    // 3: count down from IDLE
    dir = 1'b0;
    e = cyc + 1;
    push(e + 5, 3'd7, 1'b1);
    push(e + 10, 3'd6, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    drain("t3_drain");

    // 4: stop with cnt == 2, hold, resume 3 clocks to the next tick
    wait_until(e + 12);
    pulse(1'b0, 1'b1, 1'b0);
    check("t4_busy_pause", busy, 1'b0);
    repeat (20) @(negedge sys_clk);
    check("t4_hold_code", {out1, out2, out3}, 3'd6);
    check("t4_hold_busy", busy, 1'b0);
    e = cyc + 1;
    push(e + 3, 3'd5, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check("t4_resume_busy", busy, 1'b1);
    drain("t4_drain");
    pulse(1'b0, 1'b1, 1'b0);
    check("t5_pause_code", {out1, out2, out3}, 3'd5);

    // 5: single steps 5 -> 6 -> 7 -> 0, then stop to IDLE and an ignored step
    dir = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      push(cyc + 1, 3'(5 + i), i == 3);
      pulse(1'b0, 1'b0, 1'b1);
    end
    drain("t5_drain");
    pulse(1'b0, 1'b1, 1'b0);
    check("t5_idle_code", {out1, out2, out3}, 3'd0);
    check("t5_idle_busy", busy, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge sys_clk);
    check("t5_step_ignored", {out1, out2, out3}, 3'd0);

    // 6a: start+stop together in IDLE
    pulse(1'b1, 1'b1, 1'b0);
    check("t6_startstop_busy", busy, 1'b0);
    repeat (10) @(negedge sys_clk);
    check("t6_still_idle", busy, 1'b0);

    // 6b: stop on the terminal-count cycle suppresses the advance
    e = cyc + 1;
    pulse(1'b1, 1'b0, 1'b0);
    check("t6_run_busy", busy, 1'b1);
    wait_until(e + 4);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge sys_clk);
    check("t6_no_adv_code", {out1, out2, out3}, 3'd0);
    check("t6_no_adv_busy", busy, 1'b0);
    e = cyc + 1;
    push(e + 1, 3'd1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    drain("t6_resume_drain");

    // 6c: asynchronous reset mid-RUN
    @(negedge sys_clk);
    check("t6_pre_rst_busy", busy, 1'b1);
    #2 sys_rst = 1'b1;
    #1;
    check("t6_rst_code", {out1, out2, out3}, 3'd0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_tick", tick, 1'b0);
    check("t6_rst_wrap", wrap, 1'b0);
    sb.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (10) @(negedge sys_clk);
    check("t6_post_rst_busy", busy, 1'b0);
    check("t6_post_rst_code", {out1, out2, out3}, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
